// File: rtl/agc_pkg.sv
// Shared types and default loop constants for the AGC controller.
package agc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    EVAL,
    APPLY,
    HOLD
  } agc_state_e;

  // Step direction decided from one statistics sample.
  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } agc_dir_e;

  localparam int TARGET_DFLT = 85;
  localparam int DB_DFLT     = 6;
  localparam int DC_DB_DFLT  = 2;

endpackage

// File: rtl/agc_step.sv
// Deadband compare of a statistics sample plus saturating +/-1 step of a
// control value. Used for the gain code (unsigned) and the DC trim (signed).
module agc_step
  import agc_pkg::*;
#(
  parameter int VW         = 6,
  parameter bit SIGNED_VAL = 1'b0,
  parameter int CENTER     = TARGET_DFLT,
  parameter int DBAND      = DB_DFLT
) (
  input  logic [7:0]    sample,
  input  logic [VW-1:0] cur,
  input  agc_dir_e      dir_in,
  output agc_dir_e      dir_out,
  output logic [VW-1:0] nxt,
  output logic          changed
);

  int   s_val;
  logic at_max;
  logic at_min;

  // Above the band means too much signal/offset: step down; below: step up.
  always_comb begin
    if (SIGNED_VAL) s_val = $signed({{24{sample[7]}}, sample});
    else            s_val = $signed({24'd0, sample});
    dir_out = DIR_HOLD;
    if (s_val > CENTER + DBAND)      dir_out = DIR_DOWN;
    else if (s_val < CENTER - DBAND) dir_out = DIR_UP;
  end

  // A step into a rail leaves the value as is and does not count as a change.
  always_comb begin
    if (SIGNED_VAL) begin
      at_max = (cur == {1'b0, {(VW-1){1'b1}}});
      at_min = (cur == {1'b1, {(VW-1){1'b0}}});
    end else begin
      at_max = &cur;
      at_min = ~|cur;
    end
    nxt = cur;
    case (dir_in)
      DIR_UP:   if (!at_max) nxt = cur + VW'(1);
      DIR_DOWN: if (!at_min) nxt = cur - VW'(1);
      default:  nxt = cur;
    endcase
    changed = (nxt != cur);
  end

endmodule

// File: rtl/agc_loop.sv
// Per-channel closed-loop gain / DC-offset controller.
// Build option: define AGC_DC_LOOP_EN to enable the DC trim loop; otherwise
// dc is ignored and dc_trim stays 0.
//
// state | meaning
// IDLE  | manual mode, gain follows gain_manual
// WAIT  | waiting for end of integration period, then sample h0/dc
// EVAL  | register step directions from the sampled statistics
// APPLY | step gain/trim, update lock bookkeeping
// HOLD  | skip periods whose statistics straddle a change
module agc_loop
  import agc_pkg::*;
#(
  parameter int PERIOD_LOG2 = 19,
  parameter int GW          = 6,
  parameter int GAIN_INIT   = 32,
  parameter int TARGET      = TARGET_DFLT,
  parameter int DB          = DB_DFLT,
  parameter int DC_DB       = DC_DB_DFLT,
  parameter int HOLDOFF     = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          agc_en,
  input  logic [GW-1:0] gain_manual,
  input  logic [7:0]    h0,
  input  logic [7:0]    dc,
  output logic [GW-1:0] gain,
  output logic [7:0]    dc_trim,
  output logic          upd,
  output logic          lock
);

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);

  agc_state_e           state_q, state_d;
  logic [PERIOD_LOG2-1:0] cnt_q, cnt_d;
  logic [GW-1:0]        gain_q, gain_d;
  logic [7:0]           trim_q, trim_d;
  logic                 upd_q, upd_d;
  logic                 lock_q, lock_d;
  logic [LW-1:0]        lcnt_q, lcnt_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [7:0]           hs_q, hs_d;
  logic [7:0]           ds_q, ds_d;
  agc_dir_e             gdir_q, gdir_d;
  agc_dir_e             ddir_q, ddir_d;

  logic                 tick;
  agc_dir_e             g_cmp, d_cmp;
  logic [GW-1:0]        g_nxt;
  logic [7:0]           d_nxt;
  logic                 g_chg, d_chg;

  assign tick = &cnt_q;

  agc_step #(
    .VW(GW), .SIGNED_VAL(1'b0), .CENTER(TARGET), .DBAND(DB)
  ) u_gain_step (
    .sample(hs_q), .cur(gain_q), .dir_in(gdir_q),
    .dir_out(g_cmp), .nxt(g_nxt), .changed(g_chg)
  );

`ifdef AGC_DC_LOOP_EN
  agc_step #(
    .VW(8), .SIGNED_VAL(1'b1), .CENTER(0), .DBAND(DC_DB)
  ) u_dc_step (
    .sample(ds_q), .cur(trim_q), .dir_in(ddir_q),
    .dir_out(d_cmp), .nxt(d_nxt), .changed(d_chg)
  );
`else
  logic unused_dc;
  assign d_cmp     = DIR_HOLD;
  assign d_nxt     = '0;
  assign d_chg     = 1'b0;
  assign unused_dc = ^{ds_q, ddir_q};
`endif

  // Next-state and next-output computation; agc_en low overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + PERIOD_LOG2'(1);
    gain_d  = gain_q;
    trim_d  = trim_q;
    upd_d   = 1'b0;
    lock_d  = lock_q;
    lcnt_d  = lcnt_q;
    hold_d  = hold_q;
    hs_d    = hs_q;
    ds_d    = ds_q;
    gdir_d  = gdir_q;
    ddir_d  = ddir_q;
    if (!agc_en) begin
      state_d = IDLE;
      gain_d  = gain_manual;
      lock_d  = 1'b0;
      lcnt_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          gain_d  = gain_manual;
          lock_d  = 1'b0;
          state_d = WAIT;
        end
        WAIT: begin
          if (tick) begin
            hs_d    = h0;
            ds_d    = dc;
            state_d = EVAL;
          end
        end
        EVAL: begin
          gdir_d  = g_cmp;
          ddir_d  = d_cmp;
          state_d = APPLY;
        end
        APPLY: begin
          gain_d = g_nxt;
          trim_d = d_nxt;
          upd_d  = g_chg | d_chg;
          if (g_chg | d_chg) begin
            lcnt_d  = '0;
            lock_d  = 1'b0;
            hold_d  = HW'(HOLDOFF);
            state_d = (HOLDOFF == 0) ? WAIT : HOLD;
          end else begin
            if (lcnt_q < LW'(LOCK_CNT)) lcnt_d = lcnt_q + LW'(1);
            if (lcnt_d == LW'(LOCK_CNT)) lock_d = 1'b1;
            state_d = WAIT;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_q <= HW'(1)) begin
              hold_d  = '0;
              state_d = WAIT;
            end else begin
              hold_d = hold_q - HW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All controller state in one register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gain_q  <= GW'(GAIN_INIT);
      trim_q  <= '0;
      upd_q   <= 1'b0;
      lock_q  <= 1'b0;
      lcnt_q  <= '0;
      hold_q  <= '0;
      hs_q    <= '0;
      ds_q    <= '0;
      gdir_q  <= DIR_HOLD;
      ddir_q  <= DIR_HOLD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gain_q  <= gain_d;
      trim_q  <= trim_d;
      upd_q   <= upd_d;
      lock_q  <= lock_d;
      lcnt_q  <= lcnt_d;
      hold_q  <= hold_d;
      hs_q    <= hs_d;
      ds_q    <= ds_d;
      gdir_q  <= gdir_d;
      ddir_q  <= ddir_d;
    end
  end

  assign gain    = gain_q;
  assign dc_trim = trim_q;
  assign upd     = upd_q;
  assign lock    = lock_q;

endmodule

// File: tb/tb_agc_loop.sv
// Self-checking bench for agc_loop (PERIOD_LOG2=4). Honors AGC_DC_LOOP_EN.
module tb_agc_loop;

  localparam int PER    = 16;
  localparam int G_INIT = 32;
  localparam int G_MAX  = 63;
  localparam int TGT    = 85;
  localparam int DBW    = 6;
  localparam int DCDB   = 2;
  localparam int HOLD_P = 2;
  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       agc_en;
  logic [5:0] gain_manual;
  logic [7:0] h0;
  logic [7:0] dc;
  logic [5:0] gain;
  logic [7:0] dc_trim;
  logic       upd;
  logic       lock;

  int checks   = 0;
  int errors   = 0;
  int upd_seen = 0;

  // behavioural model: outputs plus period phase and pending evaluation
  int m_gain, m_trim, m_lcnt, m_skip, m_pend, m_cnt, m_hs, m_ds;
  bit m_upd, m_lock, m_idle;

  always #5 clk = ~clk;

  agc_loop #(.PERIOD_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .agc_en(agc_en), .gain_manual(gain_manual),
    .h0(h0), .dc(dc), .gain(gain), .dc_trim(dc_trim), .upd(upd), .lock(lock)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // One clock edge of the loop expressed as: every period end, if not
  // skipping, take a sample and apply its verdict two cycles later.
  task automatic model_step(input bit r, input bit en, input int gm, input int hi, input int di);
    int gd, ng, nt;
    bit tick;
`ifdef AGC_DC_LOOP_EN
    int dd;
`endif
    if (!r) begin
      m_gain = G_INIT; m_trim = 0; m_upd = 0; m_lock = 0; m_lcnt = 0;
      m_skip = 0; m_pend = 0; m_cnt = 0; m_idle = 1;
      return;
    end
    tick  = (m_cnt == PER - 1);
    m_cnt = (m_cnt + 1) % PER;
    m_upd = 0;
    if (!en) begin
      m_idle = 1; m_gain = gm; m_lock = 0; m_lcnt = 0; m_skip = 0; m_pend = 0;
    end else if (m_idle) begin
      m_idle = 0; m_gain = gm; m_lock = 0;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        gd = (m_hs > TGT + DBW) ? -1 : ((m_hs < TGT - DBW) ? 1 : 0);
        ng = clamp(m_gain + gd, 0, G_MAX);
`ifdef AGC_DC_LOOP_EN
        dd = (m_ds > DCDB) ? -1 : ((m_ds < -DCDB) ? 1 : 0);
        nt = clamp(m_trim + dd, -128, 127);
`else
        nt = 0;
`endif
        if (ng != m_gain || nt != m_trim) begin
          m_upd = 1; m_lock = 0; m_lcnt = 0; m_skip = HOLD_P;
        end else begin
          if (m_lcnt < LOCK_N) m_lcnt++;
          if (m_lcnt == LOCK_N) m_lock = 1;
        end
        m_gain = ng;
        m_trim = nt;
      end
    end else if (tick) begin
      if (m_skip > 0) m_skip--;
      else begin
        m_hs = hi; m_ds = di; m_pend = 2;
      end
    end
  endtask

  // Per-cycle compare of all outputs against the model.
  initial begin : cmp
    bit r, en;
    int gm, hi, di;
    forever begin
      @(posedge clk);
      r  = rst_n;
      en = agc_en;
      gm = int'(gain_manual);
      hi = int'(h0);
      di = int'($signed(dc));
      #1;
      model_step(r, en, gm, hi, di);
      chk("gain", int'(gain), m_gain);
      chk("dc_trim", int'($signed(dc_trim)), m_trim);
      chk("upd", int'(upd), int'(m_upd));
      chk("lock", int'(lock), int'(m_lock));
      if (upd) upd_seen++;
    end
  end

  task automatic wait_upd(input string name, input int maxc, output int waited);
    waited = -1;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if (upd) begin
        waited = n;
        break;
      end
    end
    checks++;
    if (waited < 0) begin
      errors++;
      $display("FAIL %s: got no upd, expected one within %0d cycles", name, maxc);
    end
  endtask

  function automatic logic [7:0] pick_h0();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: return 8'($urandom_range(TGT - DBW, TGT + DBW));
      1: return 8'($urandom_range(TGT + DBW + 1, 255));
      2: return 8'($urandom_range(0, TGT - DBW - 1));
      default: begin
        k = $urandom_range(0, 3);
        return 8'((k == 0) ? 78 : (k == 1) ? 79 : (k == 2) ? 91 : 92);
      end
    endcase
  endfunction

  initial begin : stim
    int w, g1, u0, n;
    rst_n = 1'b0; agc_en = 1'b1; gain_manual = 6'd32; h0 = 8'd85; dc = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_gain", int'(gain), 32);
    chk("rst_trim", int'(dc_trim), 0);
    chk("rst_lock", int'(lock), 0);
    rst_n = 1'b1;

    // in-band from reset: lock after 4 evaluations, no updates
    repeat (6 * PER) @(negedge clk);
    chk("inband_lock", int'(lock), 1);
    chk("inband_gain", int'(gain), 32);
    chk("inband_upd_count", upd_seen, 0);

    // too much signal: gain steps down once every 3 periods
    h0 = 8'd120;
    wait_upd("hi_first_upd", 40, w);
    g1 = int'(gain);
    chk("hi_first_gain", g1, 31);
    chk("hi_lock", int'(lock), 0);
    wait_upd("hi_second_upd", 80, w);
    chk("hi_gap", w, 3 * PER);
    chk("hi_second_gain", int'(gain), 30);

    // saturate at the top rail, then lock while pinned
    agc_en = 1'b0; gain_manual = 6'd62;
    @(negedge clk);
    agc_en = 1'b1; h0 = 8'd0;
    u0 = upd_seen;
    repeat (12 * PER) @(negedge clk);
    chk("sat_gain", int'(gain), 63);
    chk("sat_lock", int'(lock), 1);
    chk("sat_upd_count", upd_seen - u0, 1);

    // negative DC offset with gain in band
    agc_en = 1'b0; gain_manual = 6'd32;
    @(negedge clk);
    agc_en = 1'b1; h0 = 8'd85; dc = 8'hFB;
`ifdef AGC_DC_LOOP_EN
    wait_upd("dc_first_upd", 40, w);
    chk("dc_first_trim", int'($signed(dc_trim)), 1);
    wait_upd("dc_second_upd", 80, w);
    chk("dc_gap", w, 3 * PER);
    chk("dc_second_trim", int'($signed(dc_trim)), 2);
    chk("dc_gain_fixed", int'(gain), 32);
`else
    u0 = upd_seen;
    repeat (6 * PER) @(negedge clk);
    chk("nodc_trim", int'(dc_trim), 0);
    chk("nodc_lock", int'(lock), 1);
    chk("nodc_upd_count", upd_seen - u0, 0);
`endif

    // drop enable in HOLD, then re-enable below band
    dc = 8'd0; h0 = 8'd120;
    wait_upd("hold_upd", 60, w);
    repeat (5) @(negedge clk);
    gain_manual = 6'd10; agc_en = 1'b0;
    @(posedge clk);
    #2;
    chk("drop_gain", int'(gain), 10);
    chk("drop_lock", int'(lock), 0);
    @(negedge clk);
    h0 = 8'd50; agc_en = 1'b1;
    wait_upd("reen_upd", 40, w);
    chk("reen_gain", int'(gain), 11);

    // reset asserted while the loop is in APPLY
    rst_n = 1'b0; gain_manual = 6'd20; h0 = 8'd120;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (m_cnt != PER - 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("apply_reach", int'(m_cnt == PER - 1), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("apply_rst_gain", int'(gain), 32);
    chk("apply_rst_trim", int'(dc_trim), 0);
    chk("apply_rst_upd", int'(upd), 0);
    chk("apply_rst_lock", int'(lock), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized operation
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) h0 = pick_h0();
      if ($urandom_range(0, 79) == 0)
        dc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'(int'($urandom_range(0, 10)) - 5);
      if ($urandom_range(0, 99) == 0) gain_manual = 6'($urandom_range(0, 63));
      if (agc_en && $urandom_range(0, 299) == 0) agc_en = 1'b0;
      else if (!agc_en && $urandom_range(0, 9) == 0) agc_en = 1'b1;
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
